b06_request_gen: RTL

//  Requester/initiator for the b06 interrupt-handler handshake. Drives EQL and CONT_EQL into the

---
 rtl/b06_request_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/b06_request_gen.sv
// Requester for the b06 interrupt-handler handshake: issues a burst of EQL requests,
// counts acknowledges, captures the responder code and flags ack-wait timeouts.
module b06_request_gen #(
    parameter int CNT_W   = 4,
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15,
    parameter int GAP_CYC = 2
) (
    input  logic             clock,
    input  logic             nRESET_G,
    input  logic             START,
    input  logic [CNT_W-1:0] REQ_NUM,
    input  logic             ACKOUT,
    input  logic [1:0]       USCITE_REG,
    input  logic [1:0]       CC_MUX_REG,
    output logic             EQL,
    output logic             CONT_EQL,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [CNT_W-1:0] ACK_CNT,
    output logic [3:0]       LAST_CODE,
    output logic [2:0]       dbg_state
);

    // Handshake: EQL is held until ACKOUT is seen high in REQ; the next request is only
    // issued after ACKOUT has returned low and the idle gap has elapsed.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT_REL = 3'd2,
        S_GAP      = 3'd3,
        S_FIN      = 3'd4
    } state_t;

    // to_cnt counts completed wait cycles, so the timeout fires on the TIMEOUT-th EQL cycle.
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam bit               NO_GAP   = (GAP_CYC == 0);

    state_t           state, state_d;
    logic [CNT_W-1:0] rem, rem_d;
    logic [TO_W-1:0]  to_cnt, to_d;
    logic [CNT_W-1:0] gap_cnt, gap_d;
    logic [CNT_W-1:0] ack_d;
    logic [3:0]       code_d;
    logic             err_d, eql_d, cont_d, busy_d, done_d;

    always_ff @(posedge clock or negedge nRESET_G) begin
        if (!nRESET_G) begin
            state     <= S_IDLE;
            rem       <= '0;
            to_cnt    <= '0;
            gap_cnt   <= '0;
            EQL       <= 1'b0;
            CONT_EQL  <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            ACK_CNT   <= '0;
            LAST_CODE <= '0;
        end else begin
            state     <= state_d;
            rem       <= rem_d;
            to_cnt    <= to_d;
            gap_cnt   <= gap_d;
            EQL       <= eql_d;
            CONT_EQL  <= cont_d;
            BUSY      <= busy_d;
            DONE      <= done_d;
            ERR       <= err_d;
            ACK_CNT   <= ack_d;
            LAST_CODE <= code_d;
        end
    end

    always_comb begin
        state_d = state;
        rem_d   = rem;
        to_d    = to_cnt;
        gap_d   = gap_cnt;
        err_d   = ERR;
        ack_d   = ACK_CNT;
        code_d  = LAST_CODE;
        case (state)
            S_IDLE: begin
                if (START) begin
                    rem_d   = REQ_NUM;
                    err_d   = 1'b0;
                    ack_d   = '0;
                    to_d    = '0;
                    state_d = (REQ_NUM == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                // An ack arriving on the timeout cycle takes priority over the timeout.
                if (ACKOUT) begin
                    code_d  = {CC_MUX_REG, USCITE_REG};
                    if (ACK_CNT != '1) ack_d = ACK_CNT + CNT_W'(1);
                    rem_d   = rem - CNT_W'(1);
                    state_d = S_WAIT_REL;
                end else if (to_cnt == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    to_d = to_cnt + TO_W'(1);
                end
            end
            S_WAIT_REL: begin
                if (!ACKOUT) begin
                    if (rem == '0) begin
                        state_d = S_FIN;
                    end else if (NO_GAP) begin
                        to_d    = '0;
                        state_d = S_REQ;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    to_d    = '0;
                    state_d = S_REQ;
                end else begin
                    gap_d = gap_cnt + CNT_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so EQL/BUSY appear one cycle after START.
        eql_d  = (state_d == S_REQ);
        cont_d = eql_d && (rem_d == CNT_W'(1));
        busy_d = (state_d != S_IDLE);
        done_d = (state == S_FIN);
    end

    assign dbg_state = state;

endmodule
